// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: FSM encodings, parity and divider
// helpers, and the parameter legality check used at elaboration.
package uart_pkg;

  // TX and RX FSMs share one encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // widest data word; narrower words are zero-extended before parity
  localparam int MAX_DW = 9;

  // system clocks per oversample tick, floored
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  // odd parity makes the total count of ones odd; zero-extension is harmless
  function automatic logic parity_bit(input logic [MAX_DW-1:0] data,
                                      input logic odd);
    return odd ? ~^data : ^data;
  endfunction

  function automatic bit params_ok(input int clk_freq, input int baud_rate,
                                   input int oversample, input int data_width,
                                   input int parity_on, input int parity_odd,
                                   input int stop_bit);
    if (baud_rate <= 0 || clk_freq <= 0)                return 1'b0;
    if (oversample < 8 || oversample > 32)              return 1'b0;
    if (oversample % 2 != 0)                            return 1'b0;
    if (data_width < 5 || data_width > MAX_DW)          return 1'b0;
    if (parity_on < 0 || parity_on > 1)                 return 1'b0;
    if (parity_odd < 0 || parity_odd > 1)               return 1'b0;
    if (stop_bit < 1 || stop_bit > 2)                   return 1'b0;
    if (calc_div(clk_freq, baud_rate, oversample) < 2)  return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running modulo-DIV counter, one-cycle
// tick when it sits at its terminal value.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tick on the terminal count, wrap to zero in the same cycle
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// UART transceiver on a single clock: shared oversample tick, TX FSM with
// valid/ready handshake, 2-FF RX synchroniser and majority-vote RX FSM.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_ON  = 0,
  parameter int PARITY_ODD = 1,
  parameter int STOP_BIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err
);

  if (!params_ok(CLK_FREQ, BAUD_RATE, OVERSAMPLE, DATA_WIDTH,
                 PARITY_ON, PARITY_ODD, STOP_BIT)) begin : g_param_err
    $error("uart_core: illegal parameter combination");
  end

  localparam int   SUB_W   = $clog2(OVERSAMPLE);
  localparam int   BIT_W   = 4;
  localparam logic PAR_EN  = (PARITY_ON != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] RX_SMP0   = SUB_W'(OVERSAMPLE / 2 - 2);
  localparam logic [SUB_W-1:0] RX_SMP1   = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0] RX_VOTE   = SUB_W'(OVERSAMPLE / 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BIT - 1);

  logic tick;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // ---------------------------------------------------------------- TX
  logic [2:0]            tx_st_q,   tx_st_d;
  logic [SUB_W-1:0]      tx_sub_q,  tx_sub_d;
  logic [BIT_W-1:0]      tx_bit_q,  tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shr_q,  tx_shr_d;
  logic                  tx_par_q,  tx_par_d;
  logic                  tx_algn_q, tx_algn_d;
  logic                  tx_q,      tx_d;
  logic                  tx_bit_end, tx_stop_done, tx_hs;

  // TX sequencing. The start bit waits for one alignment tick before its
  // OVERSAMPLE ticks begin, so every later bit edge lands on a tick. The
  // final stop tick counts as idle, which lets a waiting word go out
  // back-to-back with no gap cycle.
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_sub_d  = tx_sub_q;
    tx_bit_d  = tx_bit_q;
    tx_shr_d  = tx_shr_q;
    tx_par_d  = tx_par_q;
    tx_algn_d = tx_algn_q;

    tx_bit_end   = tick && tx_algn_q && (tx_sub_q == SUB_LAST);
    tx_stop_done = (tx_st_q == ST_STOP) && tx_bit_end && (tx_bit_q == STOP_LAST);
    tx_ready     = (tx_st_q == ST_IDLE) || tx_stop_done;
    tx_hs        = tx_valid && tx_ready;

    if (tick && tx_st_q != ST_IDLE) begin
      if (!tx_algn_q) tx_algn_d = 1'b1;
      else            tx_sub_d  = tx_bit_end ? '0 : tx_sub_q + SUB_W'(1);
    end

    case (tx_st_q)
      ST_START: if (tx_bit_end) begin
        tx_st_d  = ST_DATA;
        tx_bit_d = '0;
      end
      ST_DATA: if (tx_bit_end) begin
        tx_shr_d = tx_shr_q >> 1;
        if (tx_bit_q == DATA_LAST) begin
          tx_st_d  = PAR_EN ? ST_PARITY : ST_STOP;
          tx_bit_d = '0;
        end else begin
          tx_bit_d = tx_bit_q + BIT_W'(1);
        end
      end
      ST_PARITY: if (tx_bit_end) begin
        tx_st_d  = ST_STOP;
        tx_bit_d = '0;
      end
      ST_STOP: if (tx_bit_end) begin
        if (tx_bit_q == STOP_LAST) tx_st_d  = ST_IDLE;
        else                       tx_bit_d = tx_bit_q + BIT_W'(1);
      end
      default: ;
    endcase

    if (tx_hs) begin
      tx_st_d   = ST_START;
      tx_shr_d  = tx_data;
      tx_par_d  = parity_bit(MAX_DW'(tx_data), PAR_ODD);
      tx_sub_d  = '0;
      tx_bit_d  = '0;
      tx_algn_d = tick;
    end

    // line level follows the next state so tx is a clean flop output
    case (tx_st_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_shr_d[0];
      ST_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX state; reset forces the line idle-high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= ST_IDLE;
      tx_sub_q  <= '0;
      tx_bit_q  <= '0;
      tx_shr_q  <= '0;
      tx_par_q  <= 1'b0;
      tx_algn_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_sub_q  <= tx_sub_d;
      tx_bit_q  <= tx_bit_d;
      tx_shr_q  <= tx_shr_d;
      tx_par_q  <= tx_par_d;
      tx_algn_q <= tx_algn_d;
      tx_q      <= tx_d;
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------- RX
  logic                  rx_s1_q,    rx_s1_d;
  logic                  rx_s2_q,    rx_s2_d;
  logic [2:0]            rx_st_q,    rx_st_d;
  logic [SUB_W-1:0]      rx_sub_q,   rx_sub_d;
  logic [BIT_W-1:0]      rx_bit_q,   rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shr_q,   rx_shr_d;
  logic                  rx_par_q,   rx_par_d;
  logic [1:0]            rx_smp_q,   rx_smp_d;
  logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_perr_q,  rx_perr_d;
  logic                  rx_ferr_q,  rx_ferr_d;
  logic                  rx_vote, rx_vote_tick, rx_bit_end;

  // RX sequencing. The tick that detects the start edge is count 0; a tick
  // seen with rx_sub_q == n is count n+1, so the three vote samples sit at
  // counts OVERSAMPLE/2-1 .. OVERSAMPLE/2+1 around mid-bit.
  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_st_d    = rx_st_q;
    rx_sub_d   = rx_sub_q;
    rx_bit_d   = rx_bit_q;
    rx_shr_d   = rx_shr_q;
    rx_par_d   = rx_par_q;
    rx_smp_d   = rx_smp_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;

    rx_vote      = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s2_q) |
                   (rx_smp_q[1] & rx_s2_q);
    rx_vote_tick = tick && (rx_sub_q == RX_VOTE);
    rx_bit_end   = tick && (rx_sub_q == SUB_LAST);

    if (rx_st_q == ST_IDLE) begin
      if (tick && !rx_s2_q) begin
        rx_st_d  = ST_START;
        rx_sub_d = '0;
      end
    end else if (tick) begin
      rx_sub_d = rx_bit_end ? '0 : rx_sub_q + SUB_W'(1);
      if (rx_sub_q == RX_SMP0) rx_smp_d[0] = rx_s2_q;
      if (rx_sub_q == RX_SMP1) rx_smp_d[1] = rx_s2_q;

      case (rx_st_q)
        ST_START: begin
          if (rx_vote_tick && rx_vote) begin
            rx_st_d = ST_IDLE;            // too short to be a start bit
          end else if (rx_bit_end) begin
            rx_st_d  = ST_DATA;
            rx_bit_d = '0;
          end
        end
        ST_DATA: begin
          if (rx_vote_tick) rx_shr_d = {rx_vote, rx_shr_q[DATA_WIDTH-1:1]};
          if (rx_bit_end) begin
            if (rx_bit_q == DATA_LAST) begin
              rx_st_d  = PAR_EN ? ST_PARITY : ST_STOP;
              rx_bit_d = '0;
            end else begin
              rx_bit_d = rx_bit_q + BIT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (rx_vote_tick) rx_par_d = rx_vote;
          if (rx_bit_end)   rx_st_d  = ST_STOP;
        end
        ST_STOP: begin
          // deliver at mid-stop so a new start edge is caught right away
          if (rx_vote_tick) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shr_q;
            rx_perr_d  = PAR_EN &&
                         (rx_par_q != parity_bit(MAX_DW'(rx_shr_q), PAR_ODD));
            rx_ferr_d  = ~rx_vote;
            rx_st_d    = ST_IDLE;
          end
        end
        default: rx_st_d = ST_IDLE;
      endcase
    end
  end

  // RX state; the synchroniser resets to the idle line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_st_q    <= ST_IDLE;
      rx_sub_q   <= '0;
      rx_bit_q   <= '0;
      rx_shr_q   <= '0;
      rx_par_q   <= 1'b0;
      rx_smp_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_st_q    <= rx_st_d;
      rx_sub_q   <= rx_sub_d;
      rx_bit_q   <= rx_bit_d;
      rx_shr_q   <= rx_shr_d;
      rx_par_q   <= rx_par_d;
      rx_smp_q   <= rx_smp_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: three instances (8N1, 8O1, 8N2) at DIV=10, OS=16,
// each with tx looped back to rx unless the bench overrides the line.
module tb_uart_core;

  localparam int BIT = 160;   // clocks per bit

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data [3];
  logic [2:0] tx_valid, tx_ready, tx_o, rx_i, frc_en, frc_val;
  logic [7:0] rx_data [3];
  logic [2:0] rx_valid, rx_perr, rx_ferr;

  always #5 clk = ~clk;

  assign rx_i = (frc_en & frc_val) | (~frc_en & tx_o);

  uart_core #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
              .DATA_WIDTH(8), .PARITY_ON(0), .PARITY_ODD(1), .STOP_BIT(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx(tx_o[0]), .rx(rx_i[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .rx_parity_err(rx_perr[0]), .rx_frame_err(rx_ferr[0]));

  uart_core #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
              .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_ODD(1), .STOP_BIT(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx(tx_o[1]), .rx(rx_i[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .rx_parity_err(rx_perr[1]), .rx_frame_err(rx_ferr[1]));

  uart_core #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
              .DATA_WIDTH(8), .PARITY_ON(0), .PARITY_ODD(1), .STOP_BIT(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx(tx_o[2]), .rx(rx_i[2]), .rx_data(rx_data[2]),
    .rx_valid(rx_valid[2]), .rx_parity_err(rx_perr[2]), .rx_frame_err(rx_ferr[2]));

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       ep;
    logic       ef;
  } exp_t;

  typedef struct {
    int         k;      // instance
    logic [7:0] d;
    bit         bb;     // 1: bench bit-bangs rx instead of using the TX path
    logic       pbit;   // parity bit driven when bit-banging instance 1
    logic       sbit;   // stop bit driven when bit-banging
    logic       ep;
    logic       ef;
  } vec_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rx_cnt [3] = '{0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // scoreboard: every rx_valid pulse must match the oldest expected word
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rx_valid[k] === 1'b1) begin
        exp_t e;
        rx_cnt[k]++;
        if (sbq.size() == 0) begin
          chk($sformatf("spurious rx_valid inst%0d", k), 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("rx instance", k, e.k);
          chk($sformatf("rx_data inst%0d", k), rx_data[k], e.d);
          chk($sformatf("rx_parity_err inst%0d", k), rx_perr[k], e.ep);
          chk($sformatf("rx_frame_err inst%0d", k), rx_ferr[k], e.ef);
        end
      end
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic push(input int k, input logic [7:0] d, input logic ep, input logic ef);
    exp_t e;
    e.k = k; e.d = d; e.ep = ep; e.ef = ef;
    sbq.push_back(e);
  endtask

  // handshake one word; returns just after the accepting clock edge
  task automatic send(input int k, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (tx_ready[k] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (tx_ready[k] !== 1'b1) chk("tx_ready wait timeout", 0, 1);
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    @(posedge clk);
    #1 tx_valid[k] = 1'b0;
  endtask

  task automatic bb_bit(input int k, input logic v);
    frc_val[k] = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic bitbang(input int k, input logic [7:0] d, input logic pbit, input logic sbit);
    @(negedge clk);
    frc_en[k] = 1'b1;
    bb_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) bb_bit(k, d[i]);
    if (k == 1) bb_bit(k, pbit);
    bb_bit(k, sbit);
    bb_bit(k, 1'b1);
    frc_en[k] = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sbq.size() != 0 && n < lim) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      chk("rx_valid wait timeout (words outstanding)", sbq.size(), 0);
      sbq.delete();
    end
    repeat (300) @(negedge clk);
  endtask

  vec_t       tbl [9];
  int         len, c0;
  logic [7:0] pat;

  initial begin
    tbl[0] = '{k:0, d:8'hA5, bb:0, pbit:0, sbit:1, ep:0, ef:0};
    tbl[1] = '{k:0, d:8'h00, bb:0, pbit:0, sbit:1, ep:0, ef:0};
    tbl[2] = '{k:0, d:8'hFF, bb:0, pbit:0, sbit:1, ep:0, ef:0};
    tbl[3] = '{k:1, d:8'h03, bb:0, pbit:0, sbit:1, ep:0, ef:0};
    tbl[4] = '{k:1, d:8'h80, bb:0, pbit:0, sbit:1, ep:0, ef:0};
    tbl[5] = '{k:1, d:8'h03, bb:1, pbit:0, sbit:1, ep:1, ef:0};  // wrong parity
    tbl[6] = '{k:1, d:8'h5A, bb:1, pbit:1, sbit:1, ep:0, ef:0};  // correct odd parity
    tbl[7] = '{k:0, d:8'h5A, bb:1, pbit:0, sbit:0, ep:0, ef:1};  // stop bit 0
    tbl[8] = '{k:2, d:8'h3C, bb:0, pbit:0, sbit:1, ep:0, ef:0};

    rst_n    = 1'b0;
    tx_valid = '0;
    frc_en   = '0;
    frc_val  = '1;
    for (int k = 0; k < 3; k++) tx_data[k] = '0;

    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset tx inst%0d", k), tx_o[k], 1);
      chk($sformatf("reset tx_ready inst%0d", k), tx_ready[k], 1);
      chk($sformatf("reset rx_valid inst%0d", k), rx_valid[k], 0);
      chk($sformatf("reset rx_data inst%0d", k), rx_data[k], 0);
      chk($sformatf("reset rx_parity_err inst%0d", k), rx_perr[k], 0);
      chk($sformatf("reset rx_frame_err inst%0d", k), rx_ferr[k], 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // table-driven frames
    for (int i = 0; i < 9; i++) begin
      push(tbl[i].k, tbl[i].d, tbl[i].ep, tbl[i].ef);
      if (tbl[i].bb) bitbang(tbl[i].k, tbl[i].d, tbl[i].pbit, tbl[i].sbit);
      else           send(tbl[i].k, tbl[i].d);
      drain(4000);
    end

    // 8N1 0xA5: start-bit width and data bits on the line
    push(0, 8'hA5, 0, 0);
    send(0, 8'hA5);
    chk("tx low after handshake", tx_o[0], 0);
    len = 0;
    @(negedge clk);
    while (tx_o[0] === 1'b0 && len < 400) begin len++; @(negedge clk); end
    chk($sformatf("start bit length %0d in 160..169", len), (len >= 160 && len <= 169), 1);
    pat = 8'hA5;
    repeat (80) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("0xA5 line bit %0d", i), tx_o[0], pat[i]);
      repeat (BIT) @(negedge clk);
    end
    drain(4000);

    // 8O1 0x03: parity bit on the line
    push(1, 8'h03, 0, 0);
    send(1, 8'h03);
    repeat (1525) @(negedge clk);
    chk("8O1 parity bit for 0x03", tx_o[1], odd_par(8'h03));
    drain(4000);

    // 8N2 back-to-back; tx_data changes after the first handshake
    push(2, 8'h11, 0, 0);
    push(2, 8'h22, 0, 0);
    @(negedge clk);
    tx_data[2]  = 8'h11;
    tx_valid[2] = 1'b1;
    @(posedge clk);
    #1 tx_data[2] = 8'h22;
    repeat (1300) @(negedge clk);
    chk("0x11 bit7 on line", tx_o[2], 0);
    len = 0;
    while (tx_o[2] === 1'b0 && len < 400) begin len++; @(negedge clk); end
    len = 0;
    while (tx_o[2] === 1'b1 && len < 1000) begin len++; @(negedge clk); end
    chk("stop start to next start (cycles)", len, 320);
    tx_valid[2] = 1'b0;
    drain(5000);

    // glitch: 3 ticks low is rejected
    c0 = rx_cnt[0];
    @(negedge clk);
    frc_en[0]  = 1'b1;
    frc_val[0] = 1'b0;
    repeat (30) @(negedge clk);
    frc_val[0] = 1'b1;
    repeat (400) @(negedge clk);
    frc_en[0] = 1'b0;
    chk("no rx_valid after glitch", rx_cnt[0], c0);

    // reset in data bit 3, then a clean transfer
    send(0, 8'h00);
    repeat (720) @(negedge clk);
    chk("tx low in data bit 3", tx_o[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("tx high during reset", tx_o[0], 1);
    chk("tx_ready high during reset", tx_ready[0], 1);
    chk("rx_data cleared by reset", rx_data[0], 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    c0 = rx_cnt[0];
    push(0, 8'h3C, 0, 0);
    send(0, 8'h3C);
    drain(4000);
    chk("exactly one rx_valid after reset", rx_cnt[0], c0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
